approx_mult_err_acc: RTL and testbench

Error-measurement stage placed directly downstream of the library's 8x8 approximate multipliers. Consumes each operand pair and its approximate 16-bit product, recomputes the exact product, and accumulates error statistics over a window of 2^WIN_LOG2 samples. Reported statistics are error distance (ED) sum, mean ED, maximum ED and erroneous-sample count. Used in characterisation benches and on-chip self-test to rank multiplier configurations.

---
 rtl/approx_mult_err_acc_pkg.sv | 17 +
 rtl/approx_mult_err_acc_if.sv | 28 ++
 rtl/approx_mult_err_acc_err_dist_unit.sv | 44 ++++
 rtl/approx_mult_err_acc.sv | 122 ++++++++++++
 tb/tb_approx_mult_err_acc.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/approx_mult_err_acc_pkg.sv
// Shared types and helpers for the approximate-multiplier error monitors.
package approx_mult_pkg;

   localparam int PROD_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic [PROD_W-1:0] abs_diff(input logic [PROD_W-1:0] x,
                                                  input logic [PROD_W-1:0] y);
      return (x >= y) ? (x - y) : (y - x);
   endfunction

endpackage

// File: rtl/approx_mult_err_acc_if.sv
// Sample/statistics bus between the multiplier under test and the error accumulator.
interface approx_mult_err_acc_if #(parameter int WIN_LOG2 = 8);
   import approx_mult_pkg::*;

   logic                       start;
   logic                       in_valid;
   logic                       in_ready;
   logic [7:0]                 A;
   logic [7:0]                 B;
   logic [PROD_W-1:0]          R;
   logic                       busy;
   logic                       done;
   logic [WIN_LOG2:0]          err_cnt;
   logic [PROD_W+WIN_LOG2-1:0] ed_sum;
   logic [PROD_W-1:0]          ed_max;
   logic [PROD_W-1:0]          med;

   modport master (
      output start, in_valid, A, B, R,
      input  in_ready, busy, done, err_cnt, ed_sum, ed_max, med
   );

   modport slave (
      input  start, in_valid, A, B, R,
      output in_ready, busy, done, err_cnt, ed_sum, ed_max, med
   );

endinterface

// File: rtl/approx_mult_err_acc_err_dist_unit.sv
// Exact 8x8 product and registered error distance against the approximate product.
module err_dist_unit
   import approx_mult_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_valid,
   input  logic [7:0]        i_a,
   input  logic [7:0]        i_b,
   input  logic [PROD_W-1:0] i_r,
   output logic              o_valid,
   output logic [PROD_W-1:0] o_ed,
   output logic              o_err
);

   logic [PROD_W-1:0] w_prod;
   logic [PROD_W-1:0] w_ed;
   logic              r_valid;
   logic [PROD_W-1:0] r_ed;
   logic              r_err;

   assign w_prod = {8'd0, i_a} * {8'd0, i_b};
   assign w_ed   = abs_diff(w_prod, i_r);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_ed    <= '0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= i_valid && !i_flush;
         if (i_valid) begin
            r_ed  <= w_ed;
            r_err <= |w_ed;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_ed    = r_ed;
   assign o_err   = r_err;

endmodule

// File: rtl/approx_mult_err_acc.sv
// Windowed error-distance statistics (sum, mean, max, error count) for an 8x8 approximate multiplier.
//
// state | meaning
// IDLE  | after reset, nothing accepted until start
// RUN   | window open, accepting until N samples taken, retiring until N accumulated
// DONE  | N samples retired, statistics frozen until next start
module approx_mult_err_acc
   import approx_mult_pkg::*;
#(
   parameter int WIN_LOG2 = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   approx_mult_err_acc_if.slave bus
);

   localparam int unsigned       N_I    = 1 << WIN_LOG2;
   localparam int unsigned       NL_I   = N_I - 1;
   localparam logic [WIN_LOG2:0] N_WIN  = N_I[WIN_LOG2:0];
   localparam logic [WIN_LOG2:0] N_LAST = NL_I[WIN_LOG2:0];
   localparam logic [WIN_LOG2:0] CNT_1  = {{WIN_LOG2{1'b0}}, 1'b1};

   state_e                     r_state;
   logic [WIN_LOG2:0]          r_acc_cnt;
   logic [WIN_LOG2:0]          r_ret_cnt;
   logic                       r_s1_valid;
   logic [7:0]                 r_s1_a;
   logic [7:0]                 r_s1_b;
   logic [PROD_W-1:0]          r_s1_r;
   logic [PROD_W+WIN_LOG2-1:0] r_ed_sum;
   logic [WIN_LOG2:0]          r_err_cnt;
   logic [PROD_W-1:0]          r_ed_max;

   logic                       w_accept;
   logic                       w_retire;
   logic                       w_last_retire;
   logic                       w_s2_valid;
   logic [PROD_W-1:0]          w_s2_ed;
   logic                       w_s2_err;

   assign bus.in_ready  = (r_state == RUN) && (r_acc_cnt < N_WIN);
   // start wins over a same-cycle handshake: that sample never enters the pipe
   assign w_accept      = bus.in_valid && bus.in_ready && !bus.start;
   assign w_retire      = w_s2_valid && (r_state == RUN);
   assign w_last_retire = w_retire && (r_ret_cnt == N_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else if (bus.start) begin
         r_state <= RUN;
      end else if (w_last_retire) begin
         r_state <= DONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_r     <= '0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_a <= bus.A;
            r_s1_b <= bus.B;
            r_s1_r <= bus.R;
         end
      end
   end

   err_dist_unit u_edu (
      .clk     (clk),
      .rst     (rst),
      .i_flush (bus.start),
      .i_valid (r_s1_valid),
      .i_a     (r_s1_a),
      .i_b     (r_s1_b),
      .i_r     (r_s1_r),
      .o_valid (w_s2_valid),
      .o_ed    (w_s2_ed),
      .o_err   (w_s2_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc_cnt <= '0;
         r_ret_cnt <= '0;
         r_ed_sum  <= '0;
         r_err_cnt <= '0;
         r_ed_max  <= '0;
      end else if (bus.start) begin
         r_acc_cnt <= '0;
         r_ret_cnt <= '0;
         r_ed_sum  <= '0;
         r_err_cnt <= '0;
         r_ed_max  <= '0;
      end else begin
         if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + CNT_1;
         end
         if (w_retire) begin
            r_ret_cnt <= r_ret_cnt + CNT_1;
            r_ed_sum  <= r_ed_sum + {{WIN_LOG2{1'b0}}, w_s2_ed};
            r_err_cnt <= r_err_cnt + {{WIN_LOG2{1'b0}}, w_s2_err};
            if (w_s2_ed > r_ed_max) begin
               r_ed_max <= w_s2_ed;
            end
         end
      end
   end

   assign bus.busy    = (r_state == RUN);
   assign bus.done    = (r_state == DONE);
   assign bus.ed_sum  = r_ed_sum;
   assign bus.err_cnt = r_err_cnt;
   assign bus.ed_max  = r_ed_max;
   // mean over a power-of-two window is just the upper slice of the sum
   assign bus.med     = r_ed_sum[WIN_LOG2 +: PROD_W];

endmodule

// File: tb/tb_approx_mult_err_acc.sv
// Directed bench for approx_mult_err_acc with a window of four samples.
module tb_approx_mult_err_acc;
   import approx_mult_pkg::*;

   localparam int W = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   approx_mult_err_acc_if #(.WIN_LOG2(W)) bus ();
   approx_mult_err_acc #(.WIN_LOG2(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [17:0] sum;
      logic [2:0]  err;
      logic [15:0] mx;
      logic [15:0] med;
   } win_t;

   win_t        win_q[$];
   logic [15:0] ed_q[$];
   bit          ed_chk_en = 1'b0;
   bit          prev_done = 1'b0;
   int          n_total = 0;
   int          n_bad = 0;

   // set 0: mixed errors, set 1: all ED = 1, set 2: worst case
   logic [7:0]  sa[3][4] = '{'{15, 255, 16, 3}, '{2, 10, 0, 255}, '{255, 255, 255, 255}};
   logic [7:0]  sb[3][4] = '{'{15, 255, 16, 4}, '{3, 10, 0, 1},   '{255, 255, 255, 255}};
   logic [15:0] sr[3][4] = '{'{225, 65000, 256, 8}, '{7, 99, 1, 256}, '{0, 0, 0, 0}};
   logic [15:0] se[3][4] = '{'{0, 25, 0, 4}, '{1, 1, 1, 1}, '{65025, 65025, 65025, 65025}};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
      bus.A = a;
      bus.B = b;
      bus.R = r;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (bus.in_ready) begin
            tick();
            bus.in_valid = 1'b0;
            return;
         end
         tick();
      end
      bus.in_valid = 1'b0;
      chk("accept_timeout", 64'(0), 64'(1));
   endtask

   task automatic expect_set(input int s, input win_t w);
      for (int i = 0; i < 4; i++) ed_q.push_back(se[s][i]);
      win_q.push_back(w);
   endtask

   task automatic run_window(input int s, input bit gap);
      for (int i = 0; i < 4; i++) begin
         send(sa[s][i], sb[s][i], sr[s][i]);
         if (gap && i < 3) begin
            chk("ready_in_gap", 64'(bus.in_ready), 64'(1));
            tick();
         end
      end
      chk("ready_after_last", 64'(bus.in_ready), 64'(0));
      chk("done_lat_k", 64'(bus.done), 64'(0));
      tick();
      chk("done_lat_k1", 64'(bus.done), 64'(0));
      tick();
      chk("done_lat_k2", 64'(bus.done), 64'(1));
      chk("busy_in_done", 64'(bus.busy), 64'(0));
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'(0));
      chk({nm, "_busy"},     64'(bus.busy),     64'(0));
      chk({nm, "_done"},     64'(bus.done),     64'(0));
      chk({nm, "_ed_sum"},   64'(bus.ed_sum),   64'(0));
      chk({nm, "_err_cnt"},  64'(bus.err_cnt),  64'(0));
      chk({nm, "_ed_max"},   64'(bus.ed_max),   64'(0));
      chk({nm, "_med"},      64'(bus.med),      64'(0));
   endtask

   // scoreboard monitor: per-sample ED from the stage-2 register, window stats on done rise
   always @(negedge clk) begin
      if (rst) begin
         prev_done = 1'b0;
      end else begin
         if (ed_chk_en && dut.u_edu.o_valid) begin
            if (ed_q.size() == 0) begin
               chk("ed_unexpected", 64'(dut.u_edu.o_ed), 64'hFFFF_FFFF);
            end else begin
               chk("ed", 64'(dut.u_edu.o_ed), 64'(ed_q.pop_front()));
            end
         end
         if (bus.done && !prev_done) begin
            if (win_q.size() == 0) begin
               chk("win_unexpected", 64'(bus.ed_sum), 64'hFFFF_FFFF);
            end else begin
               win_t w;
               w = win_q.pop_front();
               chk("ed_sum",  64'(bus.ed_sum),  64'(w.sum));
               chk("err_cnt", 64'(bus.err_cnt), 64'(w.err));
               chk("ed_max",  64'(bus.ed_max),  64'(w.mx));
               chk("med",     64'(bus.med),     64'(w.med));
            end
         end
         prev_done = bus.done;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.R = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // idle without start: offered samples are never taken
      bus.A = 8'd7; bus.B = 8'd9; bus.R = 16'd1;
      bus.in_valid = 1'b1;
      repeat (4) tick();
      chk_all_zero("idle");
      bus.in_valid = 1'b0;

      // back-to-back window
      ed_chk_en = 1'b1;
      pulse_start();
      chk("start_busy",  64'(bus.busy),     64'(1));
      chk("start_ready", 64'(bus.in_ready), 64'(1));
      chk("start_sum",   64'(bus.ed_sum),   64'(0));
      expect_set(0, '{sum: 18'd29, err: 3'd2, mx: 16'd25, med: 16'd7});
      run_window(0, 1'b0);

      // gapped window, restarted from DONE
      pulse_start();
      chk("restart_sum", 64'(bus.ed_sum), 64'(0));
      chk("restart_max", 64'(bus.ed_max), 64'(0));
      expect_set(0, '{sum: 18'd29, err: 3'd2, mx: 16'd25, med: 16'd7});
      run_window(0, 1'b1);

      // abort with start one cycle after the 2nd accept, with a competing sample
      ed_chk_en = 1'b0;
      pulse_start();
      send(8'd255, 8'd255, 16'd0);
      send(8'd255, 8'd255, 16'd0);
      bus.A = 8'd1; bus.B = 8'd1; bus.R = 16'd0;
      bus.in_valid = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      chk("abort_sum",   64'(bus.ed_sum),   64'(0));
      chk("abort_err",   64'(bus.err_cnt),  64'(0));
      chk("abort_busy",  64'(bus.busy),     64'(1));
      chk("abort_ready", 64'(bus.in_ready), 64'(1));
      repeat (3) tick();
      chk("abort_flush_sum", 64'(bus.ed_sum),  64'(0));
      chk("abort_flush_err", 64'(bus.err_cnt), 64'(0));
      chk("abort_flush_max", 64'(bus.ed_max),  64'(0));
      ed_q.delete();
      ed_chk_en = 1'b1;
      expect_set(1, '{sum: 18'd4, err: 3'd4, mx: 16'd1, med: 16'd1});
      run_window(1, 1'b0);

      // worst-case error distance
      pulse_start();
      expect_set(2, '{sum: 18'd260100, err: 3'd4, mx: 16'd65025, med: 16'd65025});
      run_window(2, 1'b0);

      // reset in the middle of a window
      ed_chk_en = 1'b0;
      pulse_start();
      send(sa[0][0], sb[0][0], sr[0][0]);
      send(sa[0][1], sb[0][1], sr[0][1]);
      tick();
      tick();
      chk("pre_rst_sum", 64'(bus.ed_sum), 64'(25));
      rst = 1'b1;
      #1;
      chk_all_zero("rst_async");
      tick();
      rst = 1'b0;
      repeat (2) tick();
      chk_all_zero("post_rst");
      ed_q.delete();
      ed_chk_en = 1'b1;
      pulse_start();
      expect_set(0, '{sum: 18'd29, err: 3'd2, mx: 16'd25, med: 16'd7});
      run_window(0, 1'b0);

      repeat (3) tick();
      chk("win_q_left", 64'(win_q.size()), 64'(0));
      chk("ed_q_left",  64'(ed_q.size()),  64'(0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
